// File: rtl/uart_loop_fifo_if.sv
// Signal bundle between the UART receiver/transmitter side and the
// buffered loopback controller. The master modport is the UART side that
// delivers received frames and reports transmitter status; the slave
// modport is the loopback controller itself.
interface uart_loop_fifo_if #(
    parameter int DATAWIDTH = 16,
    parameter int DEPTH     = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    // receiver side
    logic                 recv_done;
    logic [DATAWIDTH-1:0] recv_data;
    // transmitter status and housekeeping
    logic                 tx_busy;
    logic                 ovf_clr;
    // controller outputs
    logic                 send_en;
    logic [DATAWIDTH-1:0] send_data;
    logic [LW-1:0]        fifo_level;
    logic                 overflow;
    logic                 tx_timeout;

    modport master (
        output recv_done, recv_data, tx_busy, ovf_clr,
        input  send_en, send_data, fifo_level, overflow, tx_timeout
    );

    modport slave (
        input  recv_done, recv_data, tx_busy, ovf_clr,
        output send_en, send_data, fifo_level, overflow, tx_timeout
    );
endinterface

// File: rtl/uart_loop_fifo.sv
// Buffered UART loopback controller. Every rising edge of recv_done
// captures one word into a circular FIFO; a small FSM drains the FIFO into
// the transmitter one word at a time, waiting for tx_busy to rise and fall
// again, and gives up on a word if tx_busy never rises within BUSY_TIMEOUT.
module uart_loop_fifo #(
    parameter int DATAWIDTH    = 16,
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    uart_loop_fifo_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;

    logic                 d0_reg, d1_reg;
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]        level_reg;
    logic                 overflow_reg;
    logic                 send_en_reg;
    logic [DATAWIDTH-1:0] send_data_reg;
    logic                 tx_timeout_reg;

    // FIFO storage: no reset, contents are invalidated through the pointers
    // and the level counter instead.
    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic push;
    logic full;
    logic push_ok;
    logic pop;
    logic timeout_hit;

    // One push per frame no matter how long recv_done stays high.
    assign push    = d0_reg & ~d1_reg;
    // A full FIFO refuses the word even if a pop frees a slot this cycle,
    // so the decision depends only on registered occupancy.
    assign full    = (level_reg == LW'(DEPTH));
    assign push_ok = push & ~full;

    // Edge-detect pipeline for recv_done.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d0_reg <= 1'b0;
            d1_reg <= 1'b0;
        end else begin
            d0_reg <= bus.recv_done;
            d1_reg <= d0_reg;
        end
    end

    // Write port of the FIFO memory.
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= bus.recv_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap
    // naturally and the level counter tells full from empty.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow_reg <= 1'b0;
        end else if (push && full) begin
            overflow_reg <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    // FSM state and timeout counter registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: pop only when the transmitter is idle, then wait for
    // busy to rise (bounded) and fall before offering the next word.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((level_reg != '0) && !bus.tx_busy) begin
                    pop        = 1'b1;
                    cnt_next   = CW'(BUSY_TIMEOUT);
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_reg == CW'(1)) begin
                    // The decrement would reach zero on this edge, so the
                    // timeout pulse lands BUSY_TIMEOUT edges after send_en.
                    cnt_next    = '0;
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs: send_data is the registered FIFO read and only
    // changes on the edge that raises send_en.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            send_en_reg    <= 1'b0;
            send_data_reg  <= '0;
            tx_timeout_reg <= 1'b0;
        end else begin
            send_en_reg    <= pop;
            tx_timeout_reg <= timeout_hit;
            if (pop) begin
                send_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign bus.send_en    = send_en_reg;
    assign bus.send_data  = send_data_reg;
    assign bus.fifo_level = level_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.tx_timeout = tx_timeout_reg;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Bench for uart_loop_fifo: directed steps with random data, a queue-based
// model of the words that must come out, and a simple transmitter model.
module tb_uart_loop_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_loop_fifo_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) bus ();

    uart_loop_fifo #(
        .DATAWIDTH   (DW),
        .DEPTH       (DEPTH),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int sent  = 0;

    logic [DW-1:0] exp_q[$];

    logic tx_force   = 1'b0;
    logic auto_busy  = 1'b0;
    logic tx_respond = 1'b1;
    int   busy_len   = 0;

    assign bus.tx_busy = tx_force | auto_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One receiver frame: recv_done high for hi cycles, low for lo cycles.
    task automatic frame(input logic [DW-1:0] d, input int hi, input int lo, input bit accept);
        bus.recv_data = d;
        bus.recv_done = 1'b1;
        if (accept) exp_q.push_back(d);
        repeat (hi) tick();
        bus.recv_done = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || bus.tx_busy || bus.fifo_level != 0) && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_bounded"}, 32'(n < max), 1);
    endtask

    // Transmitter model: goes busy the cycle after send_en.
    always begin : tx_model
        int n;
        @(posedge sys_clk);
        #1;
        if (tx_respond && bus.send_en) begin
            n = (busy_len == 0) ? int'($urandom_range(5, 1)) : busy_len;
            auto_busy = 1'b1;
            repeat (n) @(posedge sys_clk);
            #1 auto_busy = 1'b0;
        end
    end

    // Scoreboard: every send_en must carry the oldest outstanding word.
    logic prev_en = 1'b0;
    always @(negedge sys_clk) begin
        if (bus.send_en) begin
            chk("send_pulse_width", 32'(prev_en), 0);
            if (exp_q.size() == 0) chk("send_unexpected", 1, 0);
            else chk("send_data_order", 32'(bus.send_data), 32'(exp_q.pop_front()));
            sent++;
        end
        prev_en = bus.send_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        bit early;
        logic [DW-1:0] d;

        bus.recv_done = 1'b0;
        bus.recv_data = '0;
        bus.ovf_clr   = 1'b0;
        repeat (3) tick();
        chk("rst_send_en", 32'(bus.send_en), 0);
        chk("rst_send_data", 32'(bus.send_data), 0);
        chk("rst_level", 32'(bus.fifo_level), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_tx_timeout", 32'(bus.tx_timeout), 0);
        sys_rst_n = 1'b1;
        tick();

        // single word, exact latency
        bus.recv_data = 16'hA5C3;
        bus.recv_done = 1'b1;
        exp_q.push_back(16'hA5C3);
        tick();
        chk("t1_level_k", 32'(bus.fifo_level), 0);
        chk("t1_en_k", 32'(bus.send_en), 0);
        tick();
        chk("t1_level_k1", 32'(bus.fifo_level), 1);
        chk("t1_en_k1", 32'(bus.send_en), 0);
        tick();
        chk("t1_en_k2", 32'(bus.send_en), 1);
        chk("t1_data", 32'(bus.send_data), 32'h0000A5C3);
        chk("t1_level_k2", 32'(bus.fifo_level), 0);
        bus.recv_done = 1'b0;
        wait_idle("t1", 100);
        chk("t1_sent", sent, 1);

        // burst while busy, then 10-cycle busy per word
        tx_force = 1'b1;
        busy_len = 10;
        s0 = sent;
        for (int i = 1; i <= 5; i++) frame(DW'(i), $urandom_range(3, 1), $urandom_range(2, 1), 1'b1);
        tick();
        chk("t2_level5", 32'(bus.fifo_level), 5);
        chk("t2_none_sent", sent, s0);
        tx_force = 1'b0;
        wait_idle("t2", 400);
        chk("t2_sent", sent, s0 + 5);
        chk("t2_level0", 32'(bus.fifo_level), 0);

        // overflow
        tx_force = 1'b1;
        busy_len = 0;
        s0 = sent;
        for (int i = 0; i < 9; i++) frame(DW'($urandom), $urandom_range(3, 1), $urandom_range(2, 1), i < 8);
        chk("t3_level_full", 32'(bus.fifo_level), DEPTH);
        chk("t3_overflow", 32'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t3_cleared", 32'(bus.overflow), 0);
        // a drop coinciding with a clear keeps the flag set
        bus.recv_data = DW'($urandom);
        bus.recv_done = 1'b1;
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        bus.recv_done = 1'b0;
        chk("t3_set_wins", 32'(bus.overflow), 1);
        chk("t3_level_still_full", 32'(bus.fifo_level), DEPTH);
        tick();
        chk("t3_sticky", 32'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t3_cleared2", 32'(bus.overflow), 0);
        tx_force = 1'b0;
        wait_idle("t3", 600);
        chk("t3_sent", sent, s0 + 8);

        // timeout: transmitter ignores send_en
        tx_force = 1'b1;
        s0 = sent;
        frame(DW'($urandom), 1, 1, 1'b1);
        frame(DW'($urandom), 1, 1, 1'b1);
        chk("t4_level2", 32'(bus.fifo_level), 2);
        tx_respond = 1'b0;
        tx_force = 1'b0;
        tick();
        chk("t4_send", 32'(bus.send_en), 1);
        early = 1'b0;
        for (int k = 1; k <= TMO + 1; k++) begin
            tick();
            if (k < TMO) early = early | bus.tx_timeout;
            if (k == TMO) begin
                chk("t4_no_early_timeout", 32'(early), 0);
                chk("t4_timeout", 32'(bus.tx_timeout), 1);
                chk("t4_level1", 32'(bus.fifo_level), 1);
                tx_respond = 1'b1;
            end
            if (k == TMO + 1) begin
                chk("t4_pulse_1cyc", 32'(bus.tx_timeout), 0);
                chk("t4_next_send", 32'(bus.send_en), 1);
            end
        end
        wait_idle("t4", 100);
        chk("t4_sent", sent, s0 + 2);

        // simultaneous push and pop at level 3
        tx_force = 1'b1;
        s0 = sent;
        for (int i = 0; i < 3; i++) frame(DW'($urandom), 1, 1, 1'b1);
        chk("t5_level3", 32'(bus.fifo_level), 3);
        d = DW'($urandom);
        bus.recv_data = d;
        bus.recv_done = 1'b1;
        exp_q.push_back(d);
        tick();
        tx_force = 1'b0;
        tick();
        chk("t5_level_hold", 32'(bus.fifo_level), 3);
        chk("t5_pop_same_cycle", 32'(bus.send_en), 1);
        bus.recv_done = 1'b0;
        wait_idle("t5", 200);
        chk("t5_sent", sent, s0 + 4);

        // wrap: 20 random words through the FIFO
        s0 = sent;
        for (int i = 0; i < 20; i++) frame(DW'($urandom), $urandom_range(3, 1), $urandom_range(9, 7), 1'b1);
        wait_idle("t6", 200);
        chk("t6_sent", sent, s0 + 20);
        chk("t6_level0", 32'(bus.fifo_level), 0);
        chk("t6_no_overflow", 32'(bus.overflow), 0);

        // reset in WAIT_DONE with four words queued
        tx_force = 1'b1;
        busy_len = 20;
        for (int i = 0; i < 5; i++) frame(DW'($urandom), 1, 1, 1'b1);
        chk("t7_level5", 32'(bus.fifo_level), 5);
        tx_force = 1'b0;
        n = 0;
        while (!bus.send_en && n < 20) begin
            tick();
            n++;
        end
        chk("t7_send_started", 32'(bus.send_en), 1);
        tick();
        chk("t7_level4", 32'(bus.fifo_level), 4);
        #2 sys_rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t7_rst_send_en", 32'(bus.send_en), 0);
        chk("t7_rst_send_data", 32'(bus.send_data), 0);
        chk("t7_rst_level", 32'(bus.fifo_level), 0);
        chk("t7_rst_overflow", 32'(bus.overflow), 0);
        chk("t7_rst_timeout", 32'(bus.tx_timeout), 0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        s0 = sent;
        repeat (30) tick();
        chk("t7_no_send_after_rst", sent, s0);
        chk("t7_level_after_rst", 32'(bus.fifo_level), 0);

        // recv_done already high across reset release is captured once
        busy_len = 0;
        sys_rst_n = 1'b0;
        d = DW'($urandom);
        bus.recv_data = d;
        bus.recv_done = 1'b1;
        tick();
        tick();
        sys_rst_n = 1'b1;
        exp_q.push_back(d);
        repeat (6) tick();
        bus.recv_done = 1'b0;
        wait_idle("t8", 100);
        chk("t8_sent_once", sent, s0 + 1);
        chk("t8_level0", 32'(bus.fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_loop_fifo.md
# uart_loop_fifo

Buffered UART loopback controller between the UART receiver and transmitter. Captures each received word on the rising edge of `recv_done` into a parametrised FIFO, then drains the FIFO into the transmitter one word at a time with a full `tx_busy` handshake and a timeout. Back-to-back received words are not lost while the transmitter is busy. Overflow is flagged instead of silently overwriting data.

## Interface
- `DATAWIDTH`, 16: width of received/transmitted word.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `BUSY_TIMEOUT`, 64: max cycles to wait for `tx_busy` to rise after `send_en`; ≥4.
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `recv_done`  in  1  receiver frame-done flag; level, may stay high several cycles.
- `recv_data`  in  DATAWIDTH  received word, valid while `recv_done` high.
- `tx_busy`  in  1  transmitter busy.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `send_en`  out  1  one-cycle transmit start pulse.
- `send_data`  out  DATAWIDTH  word to transmit, held until next `send_en`.
- `fifo_level`  out  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `tx_timeout`  out  1  one-cycle pulse: `tx_busy` never rose within BUSY_TIMEOUT.

## Operation
- Reset values: `send_en`=0, `send_data`=0, `fifo_level`=0, `overflow`=0, `tx_timeout`=0, FSM=IDLE, pointers=0, edge-detect regs=0.
- Edge detect: `recv_done` → d0 → d1 registers; `push` = d0 & ~d1 (one pulse per frame regardless of `recv_done` width).
- Push: on `push`, if level < DEPTH write `recv_data` (current cycle value) at wr_ptr, wr_ptr+1 mod DEPTH. If level == DEPTH, drop the word and set `overflow`. A full FIFO blocks the push even when a pop happens the same cycle.
- `overflow` clears on `ovf_clr`. Set wins over clear in the same cycle.
- Level: +1 on accepted push, −1 on pop, unchanged when both occur together.
- FSM states:
  - IDLE: if level>0 and `tx_busy`=0, pop the head into `send_data`, pulse `send_en`, load the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy`=1 go to WAIT_DONE. Otherwise decrement the counter. At 0, pulse `tx_timeout` and go to IDLE; the word counts as consumed and is not retried.
  - WAIT_DONE: when `tx_busy`=0 go to IDLE.
- The FSM never issues `send_en` while `tx_busy` is high. Exactly one `send_en` per popped word.
- Data ordering is strictly FIFO.

## Timing
- `recv_done` first sampled high at edge k: d0=1 after k, push at edge k+1, level increments after k+1.
- FIFO empty, FSM IDLE, `tx_busy`=0: pop at edge k+2, so `send_en` is high during cycle k+2..k+3 with `send_data` valid in the same cycle.
- `send_en` is always a single cycle wide. `send_data` changes only at the edge that raises `send_en`.
- Minimum spacing between `send_en` pulses: 3 cycles (IDLE→WAIT_BUSY→WAIT_DONE→IDLE) plus the transmitter busy time.
- Timeout: `tx_timeout` pulses BUSY_TIMEOUT cycles after the `send_en` edge if `tx_busy` stayed low. IDLE is entered on the same edge.
- Pointer wrap: DEPTH−1 → 0 on both pointers. Level distinguishes full from empty.
- Reset asserted mid-frame or mid-handshake: all state returns to reset values immediately and FIFO contents are discarded. After release, a `recv_done` that is still high produces a push only on a fresh rising edge through d0/d1, i.e. it is captured once, since d1=0 after reset.

## Test plan
- Single word: `recv_data`=16'hA5C3, `recv_done` high 3 cycles, `tx_busy` idle → one `send_en` 2 cycles after first sample, `send_data`=16'hA5C3, level 1→0.
- Burst under busy: hold `tx_busy`=1, push 0x0001..0x0005 → level=5, no `send_en`. Then emulate 10-cycle busy per word → 5 pulses in order 1..5, level returns to 0.
- Overflow: DEPTH=8, `tx_busy` held 1, push 9 words → level=8, `overflow`=1, the 9th word is never sent. Then `ovf_clr` → `overflow`=0.
- Timeout: `tx_busy` never responds after `send_en` → `tx_timeout` pulse exactly BUSY_TIMEOUT cycles later, the next queued word is sent after that.
- Simultaneous push/pop at level 3 → level stays 3, order preserved. Wrap: 20 words through DEPTH=8 arrive in order.
- Reset mid WAIT_DONE with level 4 → all outputs 0, level 0, no `send_en` after release until a new `recv_done` edge.
